// File: rtl/fp32_pkg.sv
// Shared FP32 field widths, special encodings and the accumulator sequencer state type.
package fp32_pkg;
  localparam int unsigned FP_E_W = 8;
  localparam int unsigned FP_M_W = 23;
  localparam int unsigned FP_W   = 32;
  localparam int unsigned BIAS   = 127;

  localparam logic [FP_E_W-1:0] EXP_MAX     = 8'hFF;
  localparam logic [FP_W-1:0]   FP_POS_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0]   FP_QNAN     = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } acc_state_e;
endpackage

// File: rtl/fp32_classify.sv
// Combinational class decode of an FP32 word (NaN, infinity, signed zero).
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [FP_W-1:0] word,
  output logic            is_nan,
  output logic            is_inf,
  output logic            is_zero
);
  logic [FP_E_W-1:0] exp_f;
  logic [FP_M_W-1:0] man_f;

  assign exp_f   = word[FP_W-2 -: FP_E_W];
  assign man_f   = word[FP_M_W-1:0];
  assign is_nan  = (exp_f == EXP_MAX) && (man_f != '0);
  assign is_inf  = (exp_f == EXP_MAX) && (man_f == '0);
  // Shifting out the sign treats +0 and -0 alike.
  assign is_zero = ((word << 1) == FP_W'(0));
endmodule

// File: rtl/fp_stream_accumulator.sv
// Frame accumulator wrapped around an external combinational/pipelined FP32 add/sub unit:
// loads operands, waits ADD_LAT cycles, captures the result and presents the frame total.
module fp_stream_accumulator
  import fp32_pkg::*;
#(
  parameter int unsigned ADD_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic [FP_W-1:0]  add_a,
  output logic [FP_W-1:0]  add_b,
  output logic             add_op,
  input  logic [FP_W-1:0]  add_p,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [FP_W-1:0]  sum_data,
  output logic [CNT_W-1:0] sum_count,
  output logic             sum_nan,
  output logic             sum_inf
);
  localparam int unsigned LAT_W = $clog2(ADD_LAT + 1);

  acc_state_e       state_q, state_d;
  logic [FP_W-1:0]  acc_q, acc_d;
  logic [FP_W-1:0]  add_a_q, add_a_d;
  logic [FP_W-1:0]  add_b_q, add_b_d;
  logic             add_op_q, add_op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic             last_pend_q, last_pend_d;
  logic             in_ready_q, in_ready_d;
  logic             sum_valid_q, sum_valid_d;
  logic             in_fire;
  logic             acc_zero;

  assign in_fire = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_op_d    = add_op_q;
    cnt_d       = cnt_q;
    lat_cnt_d   = lat_cnt_q;
    last_pend_d = last_pend_q;
    unique case (state_q)
      // First element skips the adder, which cannot take a zero running sum.
      ST_IDLE: if (in_fire) begin
        acc_d   = {in_data[FP_W-1] ^ in_sub, in_data[FP_W-2:0]};
        cnt_d   = CNT_W'(1);
        state_d = in_last ? ST_OUT : ST_RUN;
      end
      ST_RUN: if (in_fire) begin
        add_a_d     = acc_q;
        add_b_d     = in_data;
        add_op_d    = ~in_sub;
        lat_cnt_d   = LAT_W'(ADD_LAT);
        last_pend_d = in_last;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_cnt_q == LAT_W'(1)) begin
          acc_d = add_p;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          state_d = last_pend_q ? ST_OUT : ST_RUN;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      ST_OUT: if (sum_ready) begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE) || (state_d == ST_RUN);
    sum_valid_d = (state_d == ST_OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= FP_POS_ZERO;
      add_a_q     <= FP_POS_ZERO;
      add_b_q     <= FP_POS_ZERO;
      add_op_q    <= 1'b1;
      cnt_q       <= '0;
      lat_cnt_q   <= '0;
      last_pend_q <= 1'b0;
      in_ready_q  <= 1'b1;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_op_q    <= add_op_d;
      cnt_q       <= cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      last_pend_q <= last_pend_d;
      in_ready_q  <= in_ready_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  fp32_classify u_classify (
    .word    (acc_q),
    .is_nan  (sum_nan),
    .is_inf  (sum_inf),
    .is_zero (acc_zero)
  );

  // A zero sum can never also decode as a special value.
  assert property (@(posedge clk) disable iff (rst) !(acc_zero && (sum_nan || sum_inf)));

  assign in_ready  = in_ready_q;
  assign sum_valid = sum_valid_q;
  assign sum_data  = acc_q;
  assign sum_count = cnt_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_op    = add_op_q;
endmodule

// File: tb/tb_fp_stream_accumulator.sv
// Directed bench for fp_stream_accumulator with a table-driven stand-in for the FP adder.
module tb_fp_stream_accumulator;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_sub, in_last, in_ready;
  logic [31:0] in_data;
  logic [31:0] add_a, add_b, add_p;
  logic        add_op;
  logic        sum_valid, sum_ready, sum_nan, sum_inf;
  logic [31:0] sum_data;
  logic [15:0] sum_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_stream_accumulator #(.ADD_LAT(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sub(in_sub), .in_last(in_last),
    .add_a(add_a), .add_b(add_b), .add_op(add_op), .add_p(add_p),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_data(sum_data),
    .sum_count(sum_count), .sum_nan(sum_nan), .sum_inf(sum_inf)
  );

  // Hand-computed IEEE results for the operand pairs used below.
  function automatic logic [31:0] fake_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic op);
    if (op  && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (!op && a == 32'h4040_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
    if (op  && a == 32'h7F80_0000 && b == 32'h3F80_0000) return 32'h7F80_0000;
    if (!op && a == 32'h7F80_0000 && b == 32'h7F80_0000) return 32'h7FFF_FFFF;
    if (op  && a == 32'h3F00_0000 && b == 32'h3F00_0000) return 32'h3F80_0000;
    return 32'hDEAD_BEEF;
  endfunction

  always_comb add_p = fake_add(add_a, add_b, add_op);

  // Called on a negedge; returns on the negedge after the element fires.
  task automatic send_elem(input logic [31:0] d, input logic s, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_sub = s; in_last = l;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; in_data = 32'h0; in_sub = 1'b0; in_last = 1'b0;
  endtask

  task automatic consume;
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({in_ready, sum_valid, add_op} !== 3'b101) begin failures++;
      $display("FAIL reset_ctrl: ready/valid/op=%b required 101", {in_ready, sum_valid, add_op}); end
    checks++;
    if ({add_a, add_b, sum_data} !== 96'h0) begin failures++;
      $display("FAIL reset_data: a=%h b=%h sum=%h required 0", add_a, add_b, sum_data); end
    checks++;
    if (sum_count !== 16'd0) begin failures++;
      $display("FAIL reset_count: %0d required 0", sum_count); end
  endtask

  task automatic test_add;
    send_elem(32'h3F80_0000, 1'b0, 1'b0);
    send_elem(32'h4000_0000, 1'b0, 1'b1);
    checks++;
    if ({in_ready, sum_valid} !== 2'b00 || add_a !== 32'h3F80_0000 || add_b !== 32'h4000_0000
        || add_op !== 1'b1) begin failures++;
      $display("FAIL add_wait: rdy=%b vld=%b a=%h b=%h op=%b required 0 0 3f800000 40000000 1",
               in_ready, sum_valid, add_a, add_b, add_op); end
    @(negedge clk);
    checks++;
    if (sum_valid !== 1'b1 || sum_data !== 32'h4040_0000 || sum_count !== 16'd2) begin failures++;
      $display("FAIL add_result: vld=%b sum=%h cnt=%0d required 1 40400000 2",
               sum_valid, sum_data, sum_count); end
    consume();
  endtask

  task automatic test_sub;
    send_elem(32'h4040_0000, 1'b0, 1'b0);
    send_elem(32'h3F80_0000, 1'b1, 1'b1);
    checks++;
    if (add_op !== 1'b0) begin failures++;
      $display("FAIL sub_op: add_op=%b required 0", add_op); end
    @(negedge clk);
    checks++;
    if (sum_valid !== 1'b1 || sum_data !== 32'h4000_0000 || sum_count !== 16'd2) begin failures++;
      $display("FAIL sub_result: vld=%b sum=%h cnt=%0d required 1 40000000 2",
               sum_valid, sum_data, sum_count); end
    consume();
  endtask

  task automatic test_single_neg;
    send_elem(32'h4000_0000, 1'b1, 1'b1);
    checks++;
    if (sum_valid !== 1'b1 || sum_data !== 32'hC000_0000 || sum_count !== 16'd1) begin failures++;
      $display("FAIL single_neg: vld=%b sum=%h cnt=%0d required 1 c0000000 1",
               sum_valid, sum_data, sum_count); end
    checks++;
    if (add_op !== 1'b0 || add_a !== 32'h4040_0000) begin failures++;
      $display("FAIL single_no_adder: op=%b a=%h required 0 40400000", add_op, add_a); end
    consume();
  endtask

  task automatic test_backpressure;
    send_elem(32'h3F80_0000, 1'b0, 1'b1);
    in_valid = 1'b1; in_data = 32'h1234_5678; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (sum_valid !== 1'b1 || in_ready !== 1'b0 || sum_data !== 32'h3F80_0000
          || sum_count !== 16'd1) begin failures++;
        $display("FAIL bp_hold[%0d]: vld=%b rdy=%b sum=%h cnt=%0d required 1 0 3f800000 1",
                 i, sum_valid, in_ready, sum_data, sum_count); end
      @(negedge clk);
    end
    in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0;
    consume();
    checks++;
    if (in_ready !== 1'b1 || sum_valid !== 1'b0 || sum_count !== 16'd0) begin failures++;
      $display("FAIL bp_release: rdy=%b vld=%b cnt=%0d required 1 0 0",
               in_ready, sum_valid, sum_count); end
  endtask

  task automatic test_special;
    send_elem(32'h7F80_0000, 1'b0, 1'b0);
    send_elem(32'h3F80_0000, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (sum_valid !== 1'b1 || sum_data !== 32'h7F80_0000 || {sum_inf, sum_nan} !== 2'b10) begin
      failures++;
      $display("FAIL inf_plus_one: vld=%b sum=%h inf=%b nan=%b required 1 7f800000 1 0",
               sum_valid, sum_data, sum_inf, sum_nan); end
    consume();
    send_elem(32'h7F80_0000, 1'b0, 1'b0);
    send_elem(32'h7F80_0000, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (sum_valid !== 1'b1 || sum_data !== 32'h7FFF_FFFF || {sum_inf, sum_nan} !== 2'b01) begin
      failures++;
      $display("FAIL inf_minus_inf: vld=%b sum=%h inf=%b nan=%b required 1 7fffffff 0 1",
               sum_valid, sum_data, sum_inf, sum_nan); end
    consume();
  endtask

  task automatic test_reset_mid_wait;
    send_elem(32'h4040_0000, 1'b0, 1'b0);
    send_elem(32'h3F80_0000, 1'b0, 1'b1);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, sum_valid, add_op} !== 3'b101 || {add_a, add_b, sum_data} !== 96'h0
        || sum_count !== 16'd0) begin failures++;
      $display("FAIL async_reset: rdy=%b vld=%b op=%b a=%h b=%h sum=%h cnt=%0d required 1 0 1 0 0 0 0",
               in_ready, sum_valid, add_op, add_a, add_b, sum_data, sum_count); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_elem(32'h3F00_0000, 1'b0, 1'b0);
    send_elem(32'h3F00_0000, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (sum_valid !== 1'b1 || sum_data !== 32'h3F80_0000 || sum_count !== 16'd2) begin failures++;
      $display("FAIL post_reset_frame: vld=%b sum=%h cnt=%0d required 1 3f800000 2",
               sum_valid, sum_data, sum_count); end
    consume();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_sub = 1'b0; in_last = 1'b0;
    sum_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_add();
    test_sub();
    test_single_neg();
    test_backpressure();
    test_special();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
